// File: rtl/bcd_display_scanner.sv
// Four-digit multiplexed BCD display scanner with a double-buffered digit register
// and optional leading-zero blanking.
module bcd_display_scanner #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic        blank_lz,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        blank,
    output logic        err
);

    logic [15:0] r_presc;
    logic [1:0]  r_idx;
    logic [15:0] r_disp;
    logic [15:0] r_shadow;
    logic        r_pending;
    logic        r_err;

    logic        w_tick;
    logic        w_wrap;
    logic        w_valid;
    logic [3:0]  w_nib;
    logic        w_blank;

    assign w_tick  = (r_presc == 16'(SCAN_DIV - 1));
    assign w_wrap  = w_tick && (r_idx == 2'd3);
    assign w_valid = (digits_in[3:0]   <= 4'd9) && (digits_in[7:4]   <= 4'd9) &&
                     (digits_in[11:8]  <= 4'd9) && (digits_in[15:12] <= 4'd9);

    // A load on the commit edge is written after the commit, so the old shadow
    // reaches the display and the new value stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_disp    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= r_idx + 2'd1;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            if (w_wrap && r_pending) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end
            if (load) begin
                if (w_valid) begin
                    r_shadow  <= digits_in;
                    r_pending <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Digit k is blanked only when it and every more significant digit are zero.
    always_comb begin
        w_nib   = r_disp[r_idx*4 +: 4];
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = blank_lz && (r_disp[15:4]  == 12'h000);
            2'd2:    w_blank = blank_lz && (r_disp[15:8]  == 8'h00);
            2'd3:    w_blank = blank_lz && (r_disp[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end

    assign an    = w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
    assign bcd   = w_blank ? 4'hF : w_nib;
    assign blank = w_blank;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner at SCAN_DIV=4: one frame is 16 clocks,
// commits land on cycle counts that are multiples of 16 after reset release.
module tb_bcd_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic        blank_lz;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        blank;
    logic        err;

    int unsigned cyc;
    int unsigned errors;
    int unsigned checks;
    logic        exp_err;
    logic [3:0]  an_tab  [4];
    logic [3:0]  bcd_tab [4];

    bcd_display_scanner #(.SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .digits_in (digits_in),
        .blank_lz  (blank_lz),
        .bcd       (bcd),
        .an        (an),
        .blank     (blank),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int unsigned target);
        while (cyc < target) step();
    endtask

    // Entered 1ns after an edge; the strobe is sampled on the following edge.
    task automatic do_load(input logic [15:0] v);
        load      = 1'b1;
        digits_in = v;
        step();
        load      = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [3:0] e_an, input logic [3:0] e_bcd,
                       input logic e_blank);
        checks++;
        assert ({an, bcd, blank, err} === {e_an, e_bcd, e_blank, exp_err}) else begin
            errors++;
            $error("FAIL %s cyc=%0d got an=%b bcd=%h blank=%b err=%b want an=%b bcd=%h blank=%b err=%b",
                   tag, cyc, an, bcd, blank, err, e_an, e_bcd, e_blank, exp_err);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        exp_err   = 1'b0;
        rst_n     = 1'b0;
        load      = 1'b0;
        digits_in = 16'h0000;
        blank_lz  = 1'b0;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        bcd_tab[0] = 4'h4;   bcd_tab[1] = 4'h3;   bcd_tab[2] = 4'h2;   bcd_tab[3] = 4'h1;

        #12;
        chk("reset_state", 4'b1110, 4'h0, 1'b0);
        #10;
        rst_n = 1'b1;
        cyc   = 0;

        // Load 1234 while index=1; display must hold zeros until the wrap.
        step_to(4);
        do_load(16'h1234);
        chk("hold_idx1", 4'b1101, 4'h0, 1'b0);
        step_to(15);
        chk("hold_idx3", 4'b0111, 4'h0, 1'b0);
        step_to(16);
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("frame1234_d%0d_c%0d", k, j), an_tab[k], bcd_tab[k], 1'b0);
                step();
            end
        end

        // Rejected load sets sticky err and leaves display and pending alone.
        do_load(16'h12A4);
        exp_err = 1'b1;
        chk("reject_err", 4'b1110, 4'h4, 1'b0);
        step_to(48);
        chk("reject_nocommit", 4'b1110, 4'h4, 1'b0);
        do_load(16'h0005);
        step_to(64);
        chk("accept_after_err", 4'b1110, 4'h5, 1'b0);
        step_to(68);
        chk("0005_d1_noblank", 4'b1101, 4'h0, 1'b0);

        // Leading-zero blanking on 0007, then 0000 keeps digit0 lit.
        do_load(16'h0007);
        blank_lz = 1'b1;
        step_to(80);
        chk("0007_d0", 4'b1110, 4'h7, 1'b0);
        step_to(84);
        chk("0007_d1_blank", 4'b1111, 4'hF, 1'b1);
        step_to(88);
        chk("0007_d2_blank", 4'b1111, 4'hF, 1'b1);
        step_to(92);
        chk("0007_d3_blank", 4'b1111, 4'hF, 1'b1);
        do_load(16'h0000);
        step_to(96);
        chk("0000_d0", 4'b1110, 4'h0, 1'b0);
        step_to(100);
        chk("0000_d1_blank", 4'b1111, 4'hF, 1'b1);

        // 1111 pending, 2222 loaded on the commit edge.
        blank_lz = 1'b0;
        do_load(16'h1111);
        step_to(111);
        do_load(16'h2222);
        chk("coincide_d0", 4'b1110, 4'h1, 1'b0);
        step_to(124);
        chk("coincide_d3", 4'b0111, 4'h1, 1'b0);
        step_to(128);
        chk("next_frame_d0", 4'b1110, 4'h2, 1'b0);
        step_to(140);
        chk("next_frame_d3", 4'b0111, 4'h2, 1'b0);

        // 0040 with blanking, then blank_lz dropped while digit3 is active.
        blank_lz = 1'b1;
        do_load(16'h0040);
        step_to(148);
        chk("0040_d1", 4'b1101, 4'h4, 1'b0);
        step_to(152);
        chk("0040_d2_blank", 4'b1111, 4'hF, 1'b1);
        step_to(156);
        chk("0040_d3_blank", 4'b1111, 4'hF, 1'b1);
        blank_lz = 1'b0;
        #1;
        chk("0040_d3_unblank", 4'b0111, 4'h0, 1'b0);

        // Pending load then asynchronous reset mid-scan.
        step_to(157);
        do_load(16'h9876);
        #1;
        rst_n = 1'b0;
        #1;
        exp_err = 1'b0;
        chk("async_reset", 4'b1110, 4'h0, 1'b0);
        #2;
        rst_n = 1'b1;
        cyc   = 0;
        step_to(3);
        chk("first_tick_pre", 4'b1110, 4'h0, 1'b0);
        step_to(4);
        chk("first_tick", 4'b1101, 4'h0, 1'b0);
        step_to(16);
        chk("pending_discarded", 4'b1110, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
